// File: rtl/raster_sched_pkg.sv
// Shared types for the raster tile-buffer walker: FSM states and the 64-bit tile header.
package raster_sched_pkg;
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } sched_state_e;

  localparam int TILE_HDR_BYTES = 8;

  typedef struct packed {
    logic [63:0] raw;
  } tile_hdr_t;
endpackage

// File: rtl/raster_tile_sched_if.sv
// Memory read port plus tile-header stream between the walker (master) and its environment (slave).
interface raster_tile_sched_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_W      = 2
);
  logic                        mem_req_valid;
  logic [ADDR_WIDTH-1:0]       mem_req_addr;
  logic [TAG_W-1:0]            mem_req_tag;
  logic                        mem_req_ready;
  logic                        mem_rsp_valid;
  raster_sched_pkg::tile_hdr_t mem_rsp_data;
  logic [TAG_W-1:0]            mem_rsp_tag;
  logic                        mem_rsp_ready;
  logic                        tile_valid;
  raster_sched_pkg::tile_hdr_t tile_data;
  logic                        tile_ready;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready,
    output tile_valid, tile_data,
    input  tile_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready,
    input  tile_valid, tile_data,
    output tile_ready
  );
endinterface

// File: rtl/raster_tile_fifo.sv
// Header buffer: synchronous FIFO, no write-to-read bypass (data visible the cycle after the write).
// Writes when full and reads when empty are ignored; the caller's credits keep it from overflowing.
module raster_tile_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/raster_tile_sched.sv
// Tile-buffer walker: one 64-bit header read per tile, first request 1 cycle after start, headers streamed in order;
// credits stall requests while the header FIFO is committed. RASTER_SCHED_PERF_EN adds saturating stall counters.
module raster_tile_sched
  import raster_sched_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int TILE_BITS   = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] tbuf_addr,
  input  logic [TILE_BITS-1:0]  tile_count,
  output logic                  busy,
  output logic                  done,
`ifdef RASTER_SCHED_PERF_EN
  output logic [31:0]           perf_mem_stalls,
  output logic [31:0]           perf_out_stalls,
`endif
  raster_tile_sched_if.master   bus
);
  localparam int TAG_W  = $clog2(MAX_PENDING);
  localparam int CRED_W = TAG_W + 1;

  sched_state_e          state;
  logic [ADDR_WIDTH-1:0] base;
  logic [TILE_BITS-1:0]  count;
  logic [TILE_BITS-1:0]  req_idx;
  logic [TILE_BITS-1:0]  out_idx;
  logic [TAG_W-1:0]      rsp_tag_exp;
  logic [CRED_W-1:0]     credits;
  logic                  req_fire;
  logic                  handoff;
  logic                  fifo_wr;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign bus.mem_req_valid = (state == FETCH) && (credits != '0);
  assign bus.mem_req_addr  = base + ADDR_WIDTH'(req_idx) * ADDR_WIDTH'(TILE_HDR_BYTES);
  assign bus.mem_req_tag   = req_idx[TAG_W-1:0];
  assign bus.mem_rsp_ready = 1'b1;
  assign bus.tile_valid    = !fifo_empty;

  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
  assign handoff  = bus.tile_valid && bus.tile_ready;
  // Responses landing while idle belong to a walk abandoned by reset.
  assign fifo_wr  = bus.mem_rsp_valid && (state != IDLE);

  raster_tile_fifo #(
    .DEPTH (MAX_PENDING),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (bus.mem_rsp_data),
    .rd_en   (handoff),
    .rd_data (bus.tile_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      base        <= '0;
      count       <= '0;
      req_idx     <= '0;
      out_idx     <= '0;
      rsp_tag_exp <= '0;
      credits     <= CRED_W'(MAX_PENDING);
    end else begin
      done    <= 1'b0;
      credits <= credits - CRED_W'(req_fire) + CRED_W'(handoff);
      if (fifo_wr) rsp_tag_exp <= rsp_tag_exp + TAG_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            if (tile_count == '0) begin
              done <= 1'b1;
            end else begin
              state       <= FETCH;
              busy        <= 1'b1;
              base        <= tbuf_addr;
              count       <= tile_count;
              req_idx     <= '0;
              out_idx     <= '0;
              rsp_tag_exp <= '0;
            end
          end
        end
        FETCH: begin
          if (handoff) out_idx <= out_idx + TILE_BITS'(1);
          if (req_fire) begin
            req_idx <= req_idx + TILE_BITS'(1);
            if (req_idx == count - TILE_BITS'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // In-order responses mean the last handoff implies nothing is left in flight or buffered.
          if (handoff) begin
            out_idx <= out_idx + TILE_BITS'(1);
            if (out_idx == count - TILE_BITS'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RASTER_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_mem_stalls <= '0;
      perf_out_stalls <= '0;
    end else begin
      if (bus.mem_req_valid && !bus.mem_req_ready && (perf_mem_stalls != '1))
        perf_mem_stalls <= perf_mem_stalls + 32'd1;
      if (bus.tile_valid && !bus.tile_ready && (perf_out_stalls != '1))
        perf_out_stalls <= perf_out_stalls + 32'd1;
    end
  end
`endif

  a_rsp_tag_order: assert property (@(posedge clk) disable iff (reset)
    fifo_wr |-> (bus.mem_rsp_tag == rsp_tag_exp));
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_wr && fifo_full));
endmodule
